// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master/multiplexer and the SRAM slave.
// The HREADY signal is driven from the master side because it comes from the bus multiplexer.
interface ahb_sram_slave_if #(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32
);
  logic                 HSEL;
  logic [ADDRWIDTH-1:0] HADDR;
  logic                 HWRITE;
  logic [2:0]           HSIZE;
  logic [1:0]           HTRANS;
  logic                 HREADY;
  logic [DATAWIDTH-1:0] HWDATA;
  logic [DATAWIDTH-1:0] HRDATA;
  logic                 HREADYOUT;
  logic                 HRESP;

  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADY, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite word-organised SRAM slave with programmable wait states, byte-lane writes,
// read data forwarding from a completing write, and the two-cycle ERROR response.
module ahb_sram_slave #(
  parameter int ADDRWIDTH   = 32,
  parameter int DATAWIDTH   = 32,
  parameter int MEMDEPTH    = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahb_sram_slave_if.slave  bus
);

  localparam int                   IDXW      = (MEMDEPTH > 1) ? $clog2(MEMDEPTH) : 1;
  localparam logic [ADDRWIDTH-1:0] MEM_BYTES = ADDRWIDTH'(MEMDEPTH * 4);
  localparam logic [3:0]           WS        = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // Little-endian byte-lane enables for a transfer of the given size and low address bits.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'd0:    lane_mask = 4'b0001 << a;
      3'd1:    lane_mask = a[1] ? 4'b1100 : 4'b0011;
      3'd2:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [ADDRWIDTH-1:0] addr, input logic [2:0] size);
    logic bad_s;
    bad_s = 1'b0;
    if (addr >= MEM_BYTES) begin
      bad_s = 1'b1;
    end else if (size > 3'd2) begin
      bad_s = 1'b1;
    end else if ((size == 3'd1) && addr[0]) begin
      bad_s = 1'b1;
    end else if ((size == 3'd2) && (addr[1:0] != 2'b00)) begin
      bad_s = 1'b1;
    end else begin
      bad_s = 1'b0;
    end
    return bad_s;
  endfunction

  logic [DATAWIDTH-1:0] mem [MEMDEPTH];

  state_t               state_r;
  logic [3:0]           wait_cnt_r;
  logic [IDXW-1:0]      idx_r;
  logic [3:0]           lanes_r;
  logic                 write_r;
  logic [DATAWIDTH-1:0] hrdata_r;
  logic                 hreadyout_r;
  logic                 hresp_r;

  logic                 accept_s;
  logic                 start_s;
  logic                 illegal_s;
  logic                 commit_s;
  logic [IDXW-1:0]      rd_idx_s;
  logic [DATAWIDTH-1:0] fwd_word_s;
  logic                 unused_s;

  assign unused_s = bus.HTRANS[0];

  // Accept decode, error check and read word with same-edge write forwarding.
  always_comb begin
    accept_s   = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    start_s    = 1'b0;
    illegal_s  = is_illegal(bus.HADDR, bus.HSIZE);
    commit_s   = (state_r == ST_DATA) && write_r;
    rd_idx_s   = bus.HADDR[IDXW+1:2];
    fwd_word_s = mem[rd_idx_s];
    if ((state_r == ST_IDLE) || (state_r == ST_DATA) || (state_r == ST_ERR2)) begin
      start_s = accept_s;
    end else begin
      start_s = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (commit_s && lanes_r[i] && (idx_r == rd_idx_s)) begin
        fwd_word_s[8*i +: 8] = bus.HWDATA[8*i +: 8];
      end else begin
        fwd_word_s[8*i +: 8] = mem[rd_idx_s][8*i +: 8];
      end
    end
  end

  // Transfer FSM with registered HREADYOUT/HRESP/HRDATA.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= 4'd0;
      idx_r       <= '0;
      lanes_r     <= 4'b0000;
      write_r     <= 1'b0;
      hrdata_r    <= '0;
      hreadyout_r <= 1'b1;
      hresp_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_WAIT: begin
          if (wait_cnt_r == 4'd0) begin
            state_r     <= ST_DATA;
            hreadyout_r <= 1'b1;
          end else begin
            wait_cnt_r  <= wait_cnt_r - 4'd1;
          end
        end
        ST_ERR1: begin
          state_r     <= ST_ERR2;
          hreadyout_r <= 1'b1;
          hresp_r     <= 1'b1;
        end
        ST_IDLE, ST_DATA, ST_ERR2: begin
          if (start_s) begin
            idx_r   <= rd_idx_s;
            lanes_r <= lane_mask(bus.HSIZE, bus.HADDR[1:0]);
            if (illegal_s) begin
              // An erroring write is dropped here so it can never reach memory.
              write_r     <= 1'b0;
              state_r     <= ST_ERR1;
              hreadyout_r <= 1'b0;
              hresp_r     <= 1'b1;
            end else begin
              write_r <= bus.HWRITE;
              hresp_r <= 1'b0;
              if (!bus.HWRITE) begin
                hrdata_r <= fwd_word_s;
              end else begin
                hrdata_r <= hrdata_r;
              end
              if (WS != 4'd0) begin
                state_r     <= ST_WAIT;
                wait_cnt_r  <= WS - 4'd1;
                hreadyout_r <= 1'b0;
              end else begin
                state_r     <= ST_DATA;
                hreadyout_r <= 1'b1;
              end
            end
          end else begin
            write_r     <= 1'b0;
            state_r     <= ST_IDLE;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
          end
        end
        default: begin
          write_r     <= 1'b0;
          state_r     <= ST_IDLE;
          hreadyout_r <= 1'b1;
          hresp_r     <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane write into the array on the edge that ends a write data phase.
  always_ff @(posedge HCLK) begin
    if (commit_s) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes_r[i]) begin
          mem[idx_r][8*i +: 8] <= bus.HWDATA[8*i +: 8];
        end
      end
    end
  end

  assign bus.HRDATA    = hrdata_r;
  assign bus.HREADYOUT = hreadyout_r;
  assign bus.HRESP     = hresp_r;

endmodule
